ahb3lite_interconnect_slave_arbiter: RTL and testbench
======================================================

AHB3LITE_INTERCONNECT_SLAVE_ARBITER -- requirements
Module: ahb3lite_interconnect_slave_arbiter

Interface
REQ-001 SHALL have parameter MASTERS, default 3, number of masters competing for this slave port.
REQ-002 SHALL have parameter PRIORITY_BITS, default (MASTERS==1 ? 1 : $clog2(MASTERS)), width of each master priority.
REQ-003 SHALL have port HCLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port HRESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port HSEL  input  [MASTERS]  per-master select of this slave.
REQ-006 SHALL have port HTRANS  input  [MASTERS][2]  per-master transfer type.
REQ-007 SHALL have port HMASTLOCK  input  [MASTERS]  per-master locked-sequence flag.
REQ-008 SHALL have port priority_i  input  [MASTERS][PRIORITY_BITS]  per-master priority; larger value means higher priority.
REQ-009 SHALL have port HREADY  input  1  slave-side ready; 1 ends the current data phase.
REQ-010 SHALL have port grant_o  output  [MASTERS]  one-hot or all-zero registered grant.
REQ-011 SHALL have port grant_id_o  output  [$clog2(MASTERS) or 1]  binary index of the owner.
REQ-012 SHALL have port granted_o  output  1  high when grant_o is non-zero.

Function
REQ-013 Master m SHALL be requesting when HSEL[m]=1 and HTRANS[m]!=IDLE.
REQ-014 Arbitration SHALL select, among requesting masters, the one with the highest priority_i; the tie-break is given in REQ-027/028.
REQ-015 States SHALL be IDLE (no owner), OWNED (owner, unlocked), LOCKED (owner with HMASTLOCK=1).
REQ-016 An arbitration point SHALL occur on a cycle with HREADY=1 and either: state IDLE; or owner HTRANS is IDLE or NONSEQ; or owner HSEL=0; and owner HMASTLOCK=0.
REQ-017 At an arbitration point, grant_o/grant_id_o SHALL update on the next rising edge (1-cycle latency) to the winner; with no requester the state SHALL go to IDLE and the outputs SHALL go to all-zero.
REQ-018 While owner HTRANS is SEQ or BUSY, or HREADY=0, the grant SHALL be held unchanged regardless of higher-priority requests.
REQ-019 OWNED->LOCKED SHALL occur when the owner drives HMASTLOCK=1 with HREADY=1; LOCKED SHALL hold the grant until the owner HMASTLOCK=0 and HREADY=1 at a non-SEQ/BUSY cycle.
REQ-020 In LOCKED, deassertion of owner HSEL SHALL NOT release the grant while HMASTLOCK=1.
REQ-021 If the owner stays the winner at an arbitration point, the grant SHALL remain, with no idle cycle.
REQ-022 Simultaneous equal-priority requests SHALL resolve in the same cycle; no combinational path SHALL run from inputs to outputs.
REQ-023 grant_id_o SHALL equal the index of the set grant_o bit, or 0 when granted_o=0.

Reset
REQ-024 With HRESET=1 at a rising edge, state SHALL be IDLE, grant_o=0, grant_id_o=0, granted_o=0 on the following cycle.
REQ-025 Reset asserted mid-burst or in LOCKED SHALL override all holding rules.
REQ-026 The round-robin pointer SHALL reset to MASTERS-1, so index 0 wins the first tie.

Configuration
REQ-027 With macro AHB3LITE_ROUND_ROBIN_EN defined, ties among highest-priority requesters SHALL be broken round-robin: the first index above the last granted index, wrapping from MASTERS-1 to 0; the pointer updates on every new grant.
REQ-028 Without AHB3LITE_ROUND_ROBIN_EN, ties SHALL go to the lowest index and no pointer register SHALL exist.

Structure
REQ-029 HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11) SHALL come from the shared package ahb3lite_pkg.
REQ-030 State-enum typedef SHALL be local to the module.
REQ-031 The combinational max-priority search with masked tie-break SHALL be one sub-module, ahb3lite_interconnect_slave_maxsel.

Verification (MASTERS=3 unless stated)
REQ-032 Priorities {2,1,0} for m2,m1,m0, all NONSEQ, HREADY=1 -> grant_o=3'b100, grant_id_o=2 one cycle later.
REQ-033 m0 owns a 4-beat SEQ burst with priority 0 and m2 requests at priority 2 mid-burst -> grant stays 3'b001 until the last beat completes, then 3'b100 on the next edge.
REQ-034 m1 drives HMASTLOCK=1 across 3 transfers with its HSEL dropping for 1 cycle -> grant_o stays 3'b010 throughout; it is released only after HMASTLOCK=0 and HREADY=1.
REQ-035 All three masters at equal priority 1 issue continuous NONSEQ -> with AHB3LITE_ROUND_ROBIN_EN the grant order is 0,1,2,0; without it the grant stays 3'b001.
REQ-036 HREADY=0 for 5 cycles while a higher-priority request arrives -> grant unchanged; it switches on the first edge after HREADY=1.
REQ-037 HRESET=1 pulsed while in LOCKED -> grant_o=0, granted_o=0 next cycle; the first post-reset tie goes to m0.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings used by the interconnect blocks.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // SEQ and BUSY both mean the current burst is still in progress.
  function automatic logic htrans_in_burst(input logic [1:0] trans);
    return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb3lite_interconnect_slave_maxsel.sv
// Combinational winner search: highest priority among requesters, ties
// resolved by the first requester above last_idx (wrapping to index 0).
module ahb3lite_interconnect_slave_maxsel #(
  parameter int MASTERS       = 3,
  parameter int PRIORITY_BITS = 2,
  parameter int IW            = 2
) (
  input  logic [MASTERS-1:0]               req,
  input  logic [MASTERS*PRIORITY_BITS-1:0] prio,
  input  logic [IW-1:0]                    last_idx,
  output logic                             win_valid,
  output logic [IW-1:0]                    win_idx
);

  logic [PRIORITY_BITS-1:0] best_prio;
  logic                     any_req;
  logic                     picked;
  int                       cand;

  always_comb begin
    best_prio = '0;
    any_req   = 1'b0;
    picked    = 1'b0;
    cand      = 0;
    win_idx   = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (req[i] && (!any_req || prio[i*PRIORITY_BITS +: PRIORITY_BITS] > best_prio)) begin
        best_prio = prio[i*PRIORITY_BITS +: PRIORITY_BITS];
        any_req   = 1'b1;
      end
    end
    // Scan starts just above last_idx; last_idx = MASTERS-1 yields lowest-index-first.
    for (int k = 1; k <= MASTERS; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= MASTERS) cand = cand - MASTERS;
      if (!picked && req[cand] && prio[cand*PRIORITY_BITS +: PRIORITY_BITS] == best_prio) begin
        picked  = 1'b1;
        win_idx = IW'(cand);
      end
    end
    win_valid = any_req;
  end

endmodule

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave priority arbiter with burst and locked-sequence holding.
// Optional round-robin tie-break: define AHB3LITE_ROUND_ROBIN_EN.
module ahb3lite_interconnect_slave_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int MASTERS       = 3,
  parameter int PRIORITY_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [MASTERS-1:0]               HSEL,
  input  logic [2*MASTERS-1:0]             HTRANS,
  input  logic [MASTERS-1:0]               HMASTLOCK,
  input  logic [MASTERS*PRIORITY_BITS-1:0] priority_i,
  input  logic                             HREADY,
  output logic [MASTERS-1:0]               grant_o,
  output logic [((MASTERS == 1) ? 1 : $clog2(MASTERS))-1:0] grant_id_o,
  output logic                             granted_o
);

  localparam int IW = (MASTERS == 1) ? 1 : $clog2(MASTERS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e          state_reg, state_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [MASTERS-1:0] req;
  logic [IW-1:0]   last_idx;
  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic            own_sel, own_lock, arb_point;
  logic [1:0]      own_trans;

  for (genvar gi = 0; gi < MASTERS; gi++) begin : g_master
    assign req[gi]     = HSEL[gi] && (HTRANS[2*gi +: 2] != HTRANS_IDLE);
    assign grant_o[gi] = (state_reg != ST_IDLE) && (owner_reg == IW'(gi));
  end

  assign grant_id_o = owner_reg;
  assign granted_o  = (state_reg != ST_IDLE);

  ahb3lite_interconnect_slave_maxsel #(
    .MASTERS      (MASTERS),
    .PRIORITY_BITS(PRIORITY_BITS),
    .IW           (IW)
  ) u_maxsel (
    .req      (req),
    .prio     (priority_i),
    .last_idx (last_idx),
    .win_valid(win_valid),
    .win_idx  (win_idx)
  );

`ifdef AHB3LITE_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_reg;

  always_ff @(posedge HCLK) begin
    if (HRESET)                      ptr_reg <= IW'(MASTERS - 1);
    else if (arb_point && win_valid) ptr_reg <= win_idx;
  end

  assign last_idx = ptr_reg;
`else
  assign last_idx = IW'(MASTERS - 1);
`endif

  assign own_sel   = HSEL[owner_reg];
  assign own_lock  = HMASTLOCK[owner_reg];
  assign own_trans = HTRANS[2*int'(owner_reg) +: 2];

  // A locked owner never yields, even with HSEL dropped or an idle transfer.
  assign arb_point = HREADY && ((state_reg == ST_IDLE) ||
                     ((!htrans_in_burst(own_trans) || !own_sel) && !own_lock));

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    if (arb_point) begin
      if (win_valid) begin
        owner_next = win_idx;
        state_next = HMASTLOCK[win_idx] ? ST_LOCKED : ST_OWNED;
      end else begin
        owner_next = '0;
        state_next = ST_IDLE;
      end
    end else if (HREADY && state_reg == ST_OWNED && own_lock) begin
      state_next = ST_LOCKED;
    end else if (HREADY && state_reg == ST_LOCKED && !own_lock) begin
      state_next = ST_OWNED;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// Directed bench for the slave arbiter (MASTERS=3); follows AHB3LITE_ROUND_ROBIN_EN.
module tb_ahb3lite_interconnect_slave_arbiter;

  logic       clk = 1'b0;
  logic       hreset;
  logic [2:0] hsel;
  logic [5:0] htrans;
  logic [2:0] hmastlock;
  logic [5:0] prio;
  logic       hready;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       granted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ahb3lite_interconnect_slave_arbiter #(.MASTERS(3)) dut (
    .HCLK      (clk),
    .HRESET    (hreset),
    .HSEL      (hsel),
    .HTRANS    (htrans),
    .HMASTLOCK (hmastlock),
    .priority_i(prio),
    .HREADY    (hready),
    .grant_o   (grant),
    .grant_id_o(grant_id),
    .granted_o (granted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic check_grant(input string tag, input logic [2:0] exp_grant, input logic [1:0] exp_id);
    check({tag, ".grant"},   32'(grant),    32'(exp_grant));
    check({tag, ".id"},      32'(grant_id), 32'(exp_id));
    check({tag, ".granted"}, 32'(granted),  32'(exp_grant != 3'b000));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic sel, input logic [1:0] trans,
                       input logic lock, input logic [1:0] p);
    hsel[m]          = sel;
    htrans[m*2 +: 2] = trans;
    hmastlock[m]     = lock;
    prio[m*2 +: 2]   = p;
  endtask

  task automatic clear_all();
    hsel = '0; htrans = '0; hmastlock = '0; prio = '0; hready = 1'b1;
  endtask

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  logic [2:0] rr_exp [3];

  initial begin
`ifdef AHB3LITE_ROUND_ROBIN_EN
    rr_exp[0] = 3'b010; rr_exp[1] = 3'b100; rr_exp[2] = 3'b001;
`else
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b001; rr_exp[2] = 3'b001;
`endif
    clear_all();
    hreset = 1'b1;
    tick();
    check_grant("reset", 3'b000, 2'd0);
    hreset = 1'b0;

    // Highest priority wins after one edge
    set_m(0, 1, NSEQ, 0, 2'd0);
    set_m(1, 1, NSEQ, 0, 2'd1);
    set_m(2, 1, NSEQ, 0, 2'd2);
    tick();
    check_grant("prio_m2", 3'b100, 2'd2);
    clear_all();
    tick();
    check_grant("no_req", 3'b000, 2'd0);

    // Burst hold: m0 burst, m2 higher priority arrives mid-burst
    set_m(0, 1, NSEQ, 0, 2'd0);
    tick();
    check_grant("burst_start", 3'b001, 2'd0);
    set_m(2, 1, NSEQ, 0, 2'd2);
    for (int b = 0; b < 3; b++) begin
      set_m(0, 1, SEQ, 0, 2'd0);
      tick();
      check_grant($sformatf("burst_seq%0d", b), 3'b001, 2'd0);
    end
    set_m(0, 1, IDLE, 0, 2'd0);
    tick();
    check_grant("burst_end", 3'b100, 2'd2);
    clear_all();
    tick();

    // HREADY stall holds the grant
    set_m(0, 1, NSEQ, 0, 2'd0);
    tick();
    check_grant("stall_start", 3'b001, 2'd0);
    hready = 1'b0;
    set_m(2, 1, NSEQ, 0, 2'd2);
    for (int s = 0; s < 5; s++) begin
      tick();
      check(($sformatf("stall%0d.grant", s)), 32'(grant), 32'(3'b001));
    end
    hready = 1'b1;
    tick();
    check_grant("stall_release", 3'b100, 2'd2);
    clear_all();
    tick();

    // Locked sequence survives HSEL drop and higher-priority request
    set_m(0, 1, NSEQ, 0, 2'd0);
    set_m(1, 1, NSEQ, 1, 2'd1);
    tick();
    check_grant("lock_start", 3'b010, 2'd1);
    set_m(2, 1, NSEQ, 0, 2'd2);
    for (int t = 0; t < 3; t++) begin
      set_m(1, (t != 1), NSEQ, 1, 2'd1);
      tick();
      check(($sformatf("lock_xfer%0d.grant", t)), 32'(grant), 32'(3'b010));
    end
    set_m(1, 1, IDLE, 0, 2'd1);
    hready = 1'b0;
    tick();
    check("lock_unlock_wait.grant", 32'(grant), 32'(3'b010));
    hready = 1'b1;
    tick();
    check_grant("lock_release", 3'b100, 2'd2);
    clear_all();
    tick();

    // Reset in LOCKED, then first tie goes to m0
    set_m(1, 1, NSEQ, 1, 2'd1);
    tick();
    check_grant("lock_pre_reset", 3'b010, 2'd1);
    hreset = 1'b1;
    tick();
    check_grant("lock_reset", 3'b000, 2'd0);
    hreset = 1'b0;
    set_m(0, 1, NSEQ, 0, 2'd1);
    set_m(1, 1, NSEQ, 0, 2'd1);
    set_m(2, 1, NSEQ, 0, 2'd1);
    tick();
    check_grant("tie_first", 3'b001, 2'd0);
    for (int r = 0; r < 3; r++) begin
      tick();
      check(($sformatf("tie%0d.grant", r)), 32'(grant), 32'(rr_exp[r]));
    end
    clear_all();
    tick();
    check_grant("final_idle", 3'b000, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
